cam_repl: RTL and testbench
===========================

# cam_repl

Parametrised content-addressable memory with per-entry valid bits, a hardware allocator and several parallel search ports. It is the general successor to the fixed 16-entry CAM and replaces it where the pipeline needs TLB- or tag-style lookups. It places new keys itself (free slot first, round-robin victim when full), never stores a duplicate key, and supports flush and invalidate.

## Interface

Parameters:
- DATA_SIZE, 19: key/entry width in bits.
- DEPTH, 16: number of entries; power of two, ≥2.
- IDX_W, $clog2(DEPTH): entry index width.
- NSEARCH, 3: number of independent search ports.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  clear all valid bits.
- inv_en  in  1  invalidate entry inv_idx.
- inv_idx  in  IDX_W  entry to invalidate.
- wr_en  in  1  direct write of wdata into entry wr_idx, valid set.
- wr_idx  in  IDX_W  direct-write target.
- ins_en  in  1  allocating insert of wdata.
- wdata  in  DATA_SIZE  write/insert key.
- addr  in  IDX_W  read-port index.
- data  out  DATA_SIZE  entry[addr] contents (combinational).
- vld  out  1  valid[addr] (combinational).
- rdata  in  NSEARCH*DATA_SIZE  search keys; port k at [k*DATA_SIZE +: DATA_SIZE].
- hit  out  NSEARCH*DEPTH  per-port match vector.
- hit_any  out  NSEARCH  OR of the port's hit vector.
- hit_idx  out  NSEARCH*IDX_W  lowest matching index; 0 when no hit.
- multi  out  NSEARCH  more than one entry matched (fault indication).
- ins_done  out  1  registered pulse: insert performed last edge.
- ins_idx  out  IDX_W  entry written by the last performed insert.
- full  out  1  all entries valid (combinational).

## Operation

- Match for entry i, port k: valid[i] && entry[i] == rdata_k. Invalid entries never hit.
- Exactly one operation is taken per cycle, in priority flush > inv_en > wr_en > ins_en. Lower-priority requests in the same cycle are dropped, not queued, and ins_done is 0.
- flush: all valid bits are cleared. Entry data and the victim pointer are kept.
- inv_en: valid[inv_idx] is cleared. Invalidating an already invalid entry is harmless.
- wr_en: entry[wr_idx] is set to wdata and its valid bit is set. A duplicate key elsewhere is not checked; a resulting multi-hit is software's responsibility.
- ins_en, in this order:
  - (a) If wdata already matches a valid entry, the lowest such index is rewritten in place; no allocation.
  - (b) Otherwise, if any entry is invalid, the lowest invalid index is used.
  - (c) Otherwise the entry at victim pointer vp is evicted and vp advances to (vp+1) mod DEPTH, wrapping from DEPTH-1 to 0.
  - vp changes only in case (c).
- The allocator examines the current key-match against wdata (an internal compare port), not the rdata ports.

## Timing

- Search outputs (hit, hit_any, hit_idx, multi), data, vld and full are combinational from the current state and inputs.
- State updates at the rising edge. A written entry is visible to search and read starting the cycle after the write; there is no same-cycle bypass.
- ins_done and ins_idx are registered. They reflect the insert accepted at the previous edge. ins_done is high for one cycle only; ins_idx holds its value until the next insert.
- Reset (rst=0 at an edge) overrides every operation:
  - valid = 0, all entry data = 0, vp = 0.
  - ins_done = 0, ins_idx = 0.
  - Resulting outputs: hit = 0, hit_any = 0, hit_idx = 0, multi = 0, full = 0.
- Back-to-back inserts are allowed every cycle. Each one sees the state left by the previous edge.

## Test plan

- Reset with rst=0 for 2 cycles, then search 0 on all ports → hit=0, hit_any=0, full=0, data=0 at every addr, ins_done=0.
- Insert 16 distinct keys 0x100..0x10F (DEPTH=16) → ins_idx 0..15 in order, ins_done each cycle, full=1 after the 16th. Search 0x105 → hit_idx=5 and hit bit 5 only.
- Full CAM, insert 0x200 three times with different keys → evicts entries 0, 1, 2 and vp=3. Re-insert existing key 0x10A → ins_idx=10 and vp stays 3.
- Invalidate entry 7, then insert a new key → goes to entry 7, not the victim pointer. Flush → hit_any=0 for all ports while data is retained.
- Same cycle wr_en (idx 4) and ins_en → only entry 4 written, ins_done=0. Same cycle inv_en and wr_en → only the invalidate is applied.
- wr_en places key 0x0AA in entries 2 and 9 → multi=1 and hit_idx=2 on any port searching 0x0AA. Apply rst=0 mid-stream during an insert burst → all outputs return to their reset values at that edge.

Source files
------------

// File: rtl/cam_repl.sv
`default_nettype none
// ============================================================================
// Module      : cam_repl
// Description : Parametrised content-addressable memory with per-entry valid
//               bits, an allocating insert (match-in-place, lowest free slot,
//               then round-robin victim), NSEARCH parallel search ports,
//               flush and per-entry invalidate.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_repl #(
    parameter int DATA_SIZE = 19,
    parameter int DEPTH     = 16,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int NSEARCH   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         inv_en,
    input  logic [IDX_W-1:0]             inv_idx,
    input  logic                         wr_en,
    input  logic [IDX_W-1:0]             wr_idx,
    input  logic                         ins_en,
    input  logic [DATA_SIZE-1:0]         wdata,
    input  logic [IDX_W-1:0]             addr,
    output logic [DATA_SIZE-1:0]         data,
    output logic                         vld,
    input  logic [NSEARCH*DATA_SIZE-1:0] rdata,
    output logic [NSEARCH*DEPTH-1:0]     hit,
    output logic [NSEARCH-1:0]           hit_any,
    output logic [NSEARCH*IDX_W-1:0]     hit_idx,
    output logic [NSEARCH-1:0]           multi,
    output logic                         ins_done,
    output logic [IDX_W-1:0]             ins_idx,
    output logic                         full
);

    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);
    localparam logic [DEPTH-1:0] c_vec_one = DEPTH'(1);

    logic [DATA_SIZE-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [IDX_W-1:0]     r_vp;
    logic                 r_ins_done;
    logic [IDX_W-1:0]     r_ins_idx;

    logic [DEPTH-1:0]     w_ins_match;
    logic [IDX_W-1:0]     w_ins_target;
    logic                 w_evict;

    // Priority encoder: index of the lowest set bit, 0 when none is set.
    function automatic logic [IDX_W-1:0] f_lowest(input logic [DEPTH-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // Search ports: one comparator bank per port against the stored state.
    genvar k, e;
    generate
        for (k = 0; k < NSEARCH; k++) begin : g_port
            logic [DATA_SIZE-1:0] w_key;
            logic [DEPTH-1:0]     w_hit;

            assign w_key = rdata[k*DATA_SIZE +: DATA_SIZE];

            for (e = 0; e < DEPTH; e++) begin : g_entry
                assign w_hit[e] = r_valid[e] && (r_mem[e] == w_key);
            end

            assign hit[k*DEPTH +: DEPTH]     = w_hit;
            assign hit_any[k]                = |w_hit;
            assign hit_idx[k*IDX_W +: IDX_W] = f_lowest(w_hit);
            // More than one bit set: clearing the lowest set bit leaves something.
            assign multi[k]                  = (w_hit & (w_hit - c_vec_one)) != '0;
        end

        // Internal compare port used only by the allocator.
        for (e = 0; e < DEPTH; e++) begin : g_ins_cmp
            assign w_ins_match[e] = r_valid[e] && (r_mem[e] == wdata);
        end
    endgenerate

    // Allocator: existing match first, then lowest free slot, else the victim.
    always_comb begin
        w_ins_target = r_vp;
        w_evict      = 1'b0;
        if (|w_ins_match) begin
            w_ins_target = f_lowest(w_ins_match);
        end else if (!(&r_valid)) begin
            w_ins_target = f_lowest(~r_valid);
        end else begin
            w_evict      = 1'b1;
        end
    end

    // State update: one operation per cycle, flush > invalidate > write > insert.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= '0;
            r_vp       <= '0;
            r_ins_done <= 1'b0;
            r_ins_idx  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else begin
            r_ins_done <= 1'b0;
            if (flush) begin
                r_valid <= '0;
            end else if (inv_en) begin
                r_valid[inv_idx] <= 1'b0;
            end else if (wr_en) begin
                r_mem[wr_idx]   <= wdata;
                r_valid[wr_idx] <= 1'b1;
            end else if (ins_en) begin
                r_mem[w_ins_target]   <= wdata;
                r_valid[w_ins_target] <= 1'b1;
                r_ins_done            <= 1'b1;
                r_ins_idx             <= w_ins_target;
                // Power-of-two depth: the increment wraps DEPTH-1 to 0 naturally.
                if (w_evict) begin
                    r_vp <= r_vp + c_idx_one;
                end
            end
        end
    end

    assign data     = r_mem[addr];
    assign vld      = r_valid[addr];
    assign full     = &r_valid;
    assign ins_done = r_ins_done;
    assign ins_idx  = r_ins_idx;

endmodule
`default_nettype wire

// File: tb/tb_cam_repl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_repl
// Description : Self-checking bench for cam_repl. An array-based reference
//               model predicts every output each cycle; directed sequences
//               pin literal expectations; a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_repl;

    localparam int DW  = 19;
    localparam int DEP = 16;
    localparam int IW  = 4;
    localparam int NS  = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              inv_en;
    logic [IW-1:0]     inv_idx;
    logic              wr_en;
    logic [IW-1:0]     wr_idx;
    logic              ins_en;
    logic [DW-1:0]     wdata;
    logic [IW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              vld;
    logic [NS*DW-1:0]  rdata;
    logic [NS*DEP-1:0] hit;
    logic [NS-1:0]     hit_any;
    logic [NS*IW-1:0]  hit_idx;
    logic [NS-1:0]     multi;
    logic              ins_done;
    logic [IW-1:0]     ins_idx;
    logic              full;

    int n_checks;
    int n_errors;

    // Reference model state
    logic [DW-1:0] m_mem [DEP];
    bit            m_val [DEP];
    int            m_vp;
    bit            m_done;
    int            m_idx;
    bit            m_ready;

    cam_repl #(
        .DATA_SIZE(DW),
        .DEPTH    (DEP),
        .IDX_W    (IW),
        .NSEARCH  (NS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .inv_en  (inv_en),
        .inv_idx (inv_idx),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .ins_en  (ins_en),
        .wdata   (wdata),
        .addr    (addr),
        .data    (data),
        .vld     (vld),
        .rdata   (rdata),
        .hit     (hit),
        .hit_any (hit_any),
        .hit_idx (hit_idx),
        .multi   (multi),
        .ins_done(ins_done),
        .ins_idx (ins_idx),
        .full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update with the inputs seen at a rising edge.
    task automatic model_step();
        int t;
        if (!rst) begin
            for (int j = 0; j < DEP; j++) begin
                m_mem[j] = '0;
                m_val[j] = 1'b0;
            end
            m_vp    = 0;
            m_done  = 1'b0;
            m_idx   = 0;
            m_ready = 1'b1;
        end else begin
            m_done = 1'b0;
            if (flush) begin
                for (int j = 0; j < DEP; j++) m_val[j] = 1'b0;
            end else if (inv_en) begin
                m_val[inv_idx] = 1'b0;
            end else if (wr_en) begin
                m_mem[wr_idx] = wdata;
                m_val[wr_idx] = 1'b1;
            end else if (ins_en) begin
                t = -1;
                for (int j = 0; j < DEP; j++)
                    if (t < 0 && m_val[j] && m_mem[j] == wdata) t = j;
                for (int j = 0; j < DEP; j++)
                    if (t < 0 && !m_val[j]) t = j;
                if (t < 0) begin
                    t    = m_vp;
                    m_vp = (m_vp + 1) % DEP;
                end
                m_mem[t] = wdata;
                m_val[t] = 1'b1;
                m_done   = 1'b1;
                m_idx    = t;
            end
        end
    endtask

    // Compare every DUT output with what the model predicts for the current inputs.
    task automatic model_check();
        logic [DW-1:0]  key;
        logic [DEP-1:0] ehit;
        int             eidx;
        bit             efull;
        efull = 1'b1;
        for (int j = 0; j < DEP; j++) if (!m_val[j]) efull = 1'b0;
        for (int k = 0; k < NS; k++) begin
            key  = rdata[k*DW +: DW];
            ehit = '0;
            eidx = 0;
            for (int j = 0; j < DEP; j++)
                if (m_val[j] && m_mem[j] == key) ehit[j] = 1'b1;
            for (int j = DEP - 1; j >= 0; j--)
                if (ehit[j]) eidx = j;
            chk($sformatf("model hit[%0d]", k), 64'(hit[k*DEP +: DEP]), 64'(ehit));
            chk($sformatf("model hit_any[%0d]", k), 64'(hit_any[k]), 64'(ehit != '0));
            chk($sformatf("model hit_idx[%0d]", k), 64'(hit_idx[k*IW +: IW]), 64'(eidx));
            chk($sformatf("model multi[%0d]", k), 64'(multi[k]), 64'($countones(ehit) > 1));
        end
        chk("model data", 64'(data), 64'(m_mem[addr]));
        chk("model vld", 64'(vld), 64'(m_val[addr]));
        chk("model full", 64'(full), 64'(efull));
        chk("model ins_done", 64'(ins_done), 64'(m_done));
        chk("model ins_idx", 64'(ins_idx), 64'(m_idx));
    endtask

    // One clock: compare at the falling edge, model follows the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (m_ready) model_check();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        flush  = 1'b0;
        inv_en = 1'b0;
        wr_en  = 1'b0;
        ins_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] pool_key(input int n);
        return DW'(32'h100 + n);
    endfunction

    initial begin
        int r;
        n_checks = 0;
        n_errors = 0;
        m_ready  = 1'b0;
        rst      = 1'b0;
        idle();
        inv_idx  = '0;
        wr_idx   = '0;
        wdata    = '0;
        addr     = '0;
        rdata    = '0;

        // Reset state
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("reset hit", 64'(hit), 64'h0);
        chk("reset hit_any", 64'(hit_any), 64'h0);
        chk("reset full", 64'(full), 64'h0);
        chk("reset ins_done", 64'(ins_done), 64'h0);
        for (int a = 0; a < DEP; a++) begin
            addr = IW'(a);
            cycle();
            chk($sformatf("reset data[%0d]", a), 64'(data), 64'h0);
        end

        // Fill with 0x100..0x10F
        for (int i = 0; i < DEP; i++) begin
            ins_en = 1'b1;
            wdata  = DW'(32'h100 + i);
            cycle();
            chk($sformatf("fill ins_done %0d", i), 64'(ins_done), 64'h1);
            chk($sformatf("fill ins_idx %0d", i), 64'(ins_idx), 64'(i));
        end
        idle();
        chk("fill full", 64'(full), 64'h1);
        rdata[DW-1:0] = 19'h105;
        #1;
        chk("search 105 hit_idx", 64'(hit_idx[IW-1:0]), 64'h5);
        chk("search 105 hit", 64'(hit[DEP-1:0]), 64'h20);

        // Round-robin eviction, then in-place re-insert
        for (int i = 0; i < 3; i++) begin
            ins_en = 1'b1;
            wdata  = DW'(32'h200 + i);
            cycle();
            chk($sformatf("evict idx %0d", i), 64'(ins_idx), 64'(i));
        end
        wdata = 19'h10A;
        cycle();
        chk("reinsert 10A idx", 64'(ins_idx), 64'd10);
        wdata = 19'h300;
        cycle();
        chk("victim after reinsert", 64'(ins_idx), 64'd3);

        // Invalidate 7, insert lands there
        idle();
        inv_en  = 1'b1;
        inv_idx = 4'd7;
        cycle();
        idle();
        ins_en = 1'b1;
        wdata  = 19'h301;
        cycle();
        chk("free slot 7 idx", 64'(ins_idx), 64'd7);

        // Flush keeps data
        idle();
        flush = 1'b1;
        cycle();
        idle();
        rdata = {NS{19'h10B}};
        addr  = 4'd11;
        #1;
        chk("flush hit_any", 64'(hit_any), 64'h0);
        chk("flush data kept", 64'(data), 64'h10B);
        chk("flush vld", 64'(vld), 64'h0);

        // wr_en beats ins_en
        wr_en  = 1'b1;
        ins_en = 1'b1;
        wr_idx = 4'd4;
        wdata  = 19'h055;
        cycle();
        idle();
        chk("wr+ins ins_done", 64'(ins_done), 64'h0);
        addr = 4'd4;
        #1;
        chk("wr+ins data4", 64'(data), 64'h055);
        chk("wr+ins vld4", 64'(vld), 64'h1);
        addr = 4'd0;
        #1;
        chk("wr+ins vld0", 64'(vld), 64'h0);

        // inv_en beats wr_en
        inv_en  = 1'b1;
        inv_idx = 4'd4;
        wr_en   = 1'b1;
        wr_idx  = 4'd5;
        wdata   = 19'h066;
        cycle();
        idle();
        addr = 4'd4;
        #1;
        chk("inv+wr vld4", 64'(vld), 64'h0);
        addr = 4'd5;
        #1;
        chk("inv+wr data5", 64'(data), 64'h105);
        chk("inv+wr vld5", 64'(vld), 64'h0);

        // Duplicate key through direct writes
        wr_en  = 1'b1;
        wdata  = 19'h0AA;
        wr_idx = 4'd2;
        cycle();
        wr_idx = 4'd9;
        cycle();
        idle();
        rdata = {NS{19'h0AA}};
        #1;
        chk("dup multi", 64'(multi), 64'h7);
        chk("dup hit_idx", 64'(hit_idx), 64'h222);

        // Reset in the middle of an insert burst
        ins_en = 1'b1;
        wdata  = 19'h400;
        cycle();
        wdata  = 19'h401;
        cycle();
        addr = 4'd2;
        rst  = 1'b0;
        cycle();
        chk("midrst ins_done", 64'(ins_done), 64'h0);
        chk("midrst ins_idx", 64'(ins_idx), 64'h0);
        chk("midrst full", 64'(full), 64'h0);
        chk("midrst hit_any", 64'(hit_any), 64'h0);
        chk("midrst multi", 64'(multi), 64'h0);
        chk("midrst hit", 64'(hit), 64'h0);
        chk("midrst data2", 64'(data), 64'h0);
        rst = 1'b1;
        idle();

        // Randomized traffic from a small key pool so matches and evictions occur
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = 1'b1;
            r   = $urandom_range(0, 99);
            if (r < 1)       rst    = 1'b0;
            else if (r < 3)  flush  = 1'b1;
            else if (r < 13) inv_en = 1'b1;
            else if (r < 23) wr_en  = 1'b1;
            else if (r < 80) ins_en = 1'b1;
            if ($urandom_range(0, 9) == 0) ins_en = 1'b1;
            if ($urandom_range(0, 19) == 0) wr_en = 1'b1;
            inv_idx = IW'($urandom_range(0, DEP - 1));
            wr_idx  = IW'($urandom_range(0, DEP - 1));
            addr    = IW'($urandom_range(0, DEP - 1));
            wdata   = pool_key($urandom_range(0, 31));
            for (int k = 0; k < NS; k++)
                rdata[k*DW +: DW] = pool_key($urandom_range(0, 31));
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
